hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core.
- Generates per-stage write enables (xxW) and flush strobes (xxRST) for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable.
- Resolves four hazard classes: load-use, taken branch/jump, instruction-cache miss and data-cache miss.
- Tracks halt and counts stall cycles for performance debug.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/hazard_detect.sv | 24 ++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the core's pipeline sequencing logic.
package cpu_types_pkg;

    // Hazard controller operating states.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

    // Architectural register index.
    typedef logic [4:0] regbits_t;

    // Per-stage enables and flushes for the pipeline registers.
    typedef struct packed {
        logic pc_en;
        logic ifid_w;
        logic idex_w;
        logic exmem_w;
        logic memwb_w;
        logic ifid_rst;
        logic idex_rst;
        logic exmem_rst;
        logic memwb_rst;
    } pipe_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination is a source of the
// instruction in ID. Writes to $0 never create a dependency.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_mem_to_reg,
    input  regbits_t ex_rt,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_uses_rt,
    output logic     load_use
);

    logic rs_match;
    logic rt_match;

    // Compare the load destination against both ID source fields.
    always_comb begin
        rs_match = (ex_rt == id_rs);
        rt_match = id_uses_rt && (ex_rt == id_rt);
        load_use = ex_mem_to_reg && (ex_rt != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-stage write enables and flushes,
// PC enable, sticky halt and a saturating stall-cycle counter.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             memREN,
    input  logic             memWEN,
    input  logic             exMemToReg,
    input  regbits_t         exrt,
    input  regbits_t         idrs,
    input  regbits_t         idrt,
    input  logic             idUsesRt,
    input  logic             exBrTaken,
    input  logic             idJump,
    input  logic             wbHALT,
    output logic             pcEN,
    output logic             ifidW,
    output logic             idexW,
    output logic             exmemW,
    output logic             memwbW,
    output logic             ifidRST,
    output logic             idexRST,
    output logic             exmemRST,
    output logic             memwbRST,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    hazard_state_t    state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    pipe_ctrl_t       ctrl;
    logic             dmiss;
    logic             load_use;

    hazard_detect u_detect (
        .ex_mem_to_reg (exMemToReg),
        .ex_rt         (exrt),
        .id_rs         (idrs),
        .id_rt         (idrt),
        .id_uses_rt    (idUsesRt),
        .load_use      (load_use)
    );

    // A memory-stage access that has not completed this cycle.
    always_comb begin
        dmiss = (memREN || memWEN) && !dhit;
    end

    // Prioritised pipeline control; a flushed stage never also loads.
    always_comb begin
        // NOTE: every field gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        ctrl = '0;
        if (RST) begin
            ctrl.ifid_rst  = 1'b1;
            ctrl.idex_rst  = 1'b1;
            ctrl.exmem_rst = 1'b1;
            ctrl.memwb_rst = 1'b1;
        end else if (state_q != HALTED) begin
            if (dmiss) begin
                // Freeze everything and bubble WB so the MEM result is not
                // written twice.
                ctrl.memwb_rst = 1'b1;
            end else if (exBrTaken) begin
                // Redirect even on an icache miss; the wrong-path fetch is
                // flushed.
                ctrl.pc_en     = 1'b1;
                ctrl.ifid_rst  = 1'b1;
                ctrl.idex_rst  = 1'b1;
                ctrl.exmem_w   = 1'b1;
                ctrl.memwb_w   = 1'b1;
            end else if (load_use) begin
                // Hold IF/ID and PC, insert one bubble into EX.
                ctrl.idex_rst  = 1'b1;
                ctrl.exmem_w   = 1'b1;
                ctrl.memwb_w   = 1'b1;
            end else if (idJump) begin
                ctrl.pc_en     = ihit;
                ctrl.ifid_rst  = 1'b1;
                ctrl.idex_w    = 1'b1;
                ctrl.exmem_w   = 1'b1;
                ctrl.memwb_w   = 1'b1;
            end else if (!ihit) begin
                ctrl.ifid_rst  = 1'b1;
                ctrl.idex_w    = 1'b1;
                ctrl.exmem_w   = 1'b1;
                ctrl.memwb_w   = 1'b1;
            end else begin
                ctrl.pc_en     = 1'b1;
                ctrl.ifid_w    = 1'b1;
                ctrl.idex_w    = 1'b1;
                ctrl.exmem_w   = 1'b1;
                ctrl.memwb_w   = 1'b1;
            end
        end
    end

    // Next state: halt beats a data miss; DWAIT releases once dhit arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, DWAIT: begin
                if (wbHALT)     state_d = HALTED;
                else if (dmiss) state_d = DWAIT;
                else            state_d = RUN;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Count cycles the PC was held while running; saturate instead of wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != HALTED) && !ctrl.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pcEN      = ctrl.pc_en;
    assign ifidW     = ctrl.ifid_w;
    assign idexW     = ctrl.idex_w;
    assign exmemW    = ctrl.exmem_w;
    assign memwbW    = ctrl.memwb_w;
    assign ifidRST   = ctrl.ifid_rst;
    assign idexRST   = ctrl.idex_rst;
    assign exmemRST  = ctrl.exmem_rst;
    assign memwbRST  = ctrl.memwb_rst;
    assign halted    = (state_q == HALTED);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_hazard_ctrl;
    import cpu_types_pkg::*;

    localparam int CNT_W = 4;

    // Output vector order: pcEN, ifidW, idexW, exmemW, memwbW,
    //                      ifidRST, idexRST, exmemRST, memwbRST
    localparam logic [8:0] O_DEF   = 9'b1_1111_0000;
    localparam logic [8:0] O_DMISS = 9'b0_0000_0001;
    localparam logic [8:0] O_BR    = 9'b1_0011_1100;
    localparam logic [8:0] O_LU    = 9'b0_0011_0100;
    localparam logic [8:0] O_JHIT  = 9'b1_0111_1000;
    localparam logic [8:0] O_JMISS = 9'b0_0111_1000;
    localparam logic [8:0] O_IMISS = 9'b0_0111_1000;
    localparam logic [8:0] O_RST   = 9'b0_0000_1111;
    localparam logic [8:0] O_HALT  = 9'b0_0000_0000;

    logic CLK, RST, ihit, dhit, memREN, memWEN, exMemToReg;
    logic idUsesRt, exBrTaken, idJump, wbHALT;
    regbits_t exrt, idrs, idrt;
    logic pcEN, ifidW, idexW, exmemW, memwbW;
    logic ifidRST, idexRST, exmemRST, memwbRST, halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [8:0] outs;

    int assertions = 0;
    int failures   = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .memREN(memREN), .memWEN(memWEN), .exMemToReg(exMemToReg),
        .exrt(exrt), .idrs(idrs), .idrt(idrt), .idUsesRt(idUsesRt),
        .exBrTaken(exBrTaken), .idJump(idJump), .wbHALT(wbHALT),
        .pcEN(pcEN), .ifidW(ifidW), .idexW(idexW), .exmemW(exmemW),
        .memwbW(memwbW), .ifidRST(ifidRST), .idexRST(idexRST),
        .exmemRST(exmemRST), .memwbRST(memwbRST), .halted(halted),
        .stall_cnt(stall_cnt)
    );

    assign outs = {pcEN, ifidW, idexW, exmemW, memwbW,
                   ifidRST, idexRST, exmemRST, memwbRST};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; memREN = 1'b0; memWEN = 1'b0;
        exMemToReg = 1'b0; exrt = '0; idrs = '0; idrt = '0; idUsesRt = 1'b0;
        exBrTaken = 1'b0; idJump = 1'b0; wbHALT = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        @(negedge CLK);
        assertions++;
        if (outs !== O_RST) begin
            $display("FAIL reset_outs: got %b expected %b", outs, O_RST); failures++;
        end
        assertions++;
        if (halted !== 1'b0 || stall_cnt !== '0 || dut.state_q !== RUN) begin
            $display("FAIL reset_state: halted=%b cnt=%0d state=%0d expected 0/0/RUN",
                     halted, stall_cnt, dut.state_q);
            failures++;
        end
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        assertions++;
        if (outs !== O_DEF) begin
            $display("FAIL reset_release: got %b expected %b", outs, O_DEF); failures++;
        end
        exp_cnt = '0;
        next_cycle();
    endtask

    task automatic test_load_use();
        exMemToReg = 1'b1; exrt = 5'd5; idrs = 5'd5;
        @(negedge CLK);
        assertions++;
        if (outs !== O_LU) begin
            $display("FAIL load_use_rs: got %b expected %b", outs, O_LU); failures++;
        end
        next_cycle();
        exp_cnt = sat_inc(exp_cnt);
        exMemToReg = 1'b0;
        @(negedge CLK);
        assertions++;
        if (outs !== O_DEF || stall_cnt !== exp_cnt) begin
            $display("FAIL load_use_after: outs=%b cnt=%0d expected %b cnt=%0d",
                     outs, stall_cnt, O_DEF, exp_cnt);
            failures++;
        end
        next_cycle();
        // rt dependency counts only when the ID instruction reads rt.
        exMemToReg = 1'b1; exrt = 5'd7; idrs = 5'd3; idrt = 5'd7; idUsesRt = 1'b1;
        @(negedge CLK);
        assertions++;
        if (outs !== O_LU) begin
            $display("FAIL load_use_rt: got %b expected %b", outs, O_LU); failures++;
        end
        next_cycle();
        exp_cnt = sat_inc(exp_cnt);
        idUsesRt = 1'b0;
        @(negedge CLK);
        assertions++;
        if (outs !== O_DEF) begin
            $display("FAIL load_rt_unused: got %b expected %b", outs, O_DEF); failures++;
        end
        next_cycle();
        idle();
    endtask

    task automatic test_load_r0();
        exMemToReg = 1'b1; exrt = 5'd0; idrs = 5'd0; idrt = 5'd0; idUsesRt = 1'b1;
        @(negedge CLK);
        assertions++;
        if (outs !== O_DEF || stall_cnt !== exp_cnt) begin
            $display("FAIL load_r0: outs=%b cnt=%0d expected %b cnt=%0d",
                     outs, stall_cnt, O_DEF, exp_cnt);
            failures++;
        end
        next_cycle();
        idle();
    endtask

    task automatic test_branch();
        exBrTaken = 1'b1; ihit = 1'b0;
        @(negedge CLK);
        assertions++;
        if (outs !== O_BR) begin
            $display("FAIL branch_imiss: got %b expected %b", outs, O_BR); failures++;
        end
        next_cycle();
        // Branch outranks a simultaneous load-use.
        ihit = 1'b1; exMemToReg = 1'b1; exrt = 5'd9; idrs = 5'd9;
        @(negedge CLK);
        assertions++;
        if (outs !== O_BR) begin
            $display("FAIL branch_over_lu: got %b expected %b", outs, O_BR); failures++;
        end
        next_cycle();
        idle();
        @(negedge CLK);
        assertions++;
        if (stall_cnt !== exp_cnt) begin
            $display("FAIL branch_cnt: got %0d expected %0d", stall_cnt, exp_cnt); failures++;
        end
        next_cycle();
    endtask

    task automatic test_jump_imiss();
        idJump = 1'b1;
        @(negedge CLK);
        assertions++;
        if (outs !== O_JHIT) begin
            $display("FAIL jump_hit: got %b expected %b", outs, O_JHIT); failures++;
        end
        next_cycle();
        ihit = 1'b0;
        @(negedge CLK);
        assertions++;
        if (outs !== O_JMISS) begin
            $display("FAIL jump_miss: got %b expected %b", outs, O_JMISS); failures++;
        end
        next_cycle();
        exp_cnt = sat_inc(exp_cnt);
        idJump = 1'b0;
        @(negedge CLK);
        assertions++;
        if (outs !== O_IMISS) begin
            $display("FAIL imiss: got %b expected %b", outs, O_IMISS); failures++;
        end
        next_cycle();
        exp_cnt = sat_inc(exp_cnt);
        idle();
        @(negedge CLK);
        assertions++;
        if (stall_cnt !== exp_cnt) begin
            $display("FAIL jump_imiss_cnt: got %0d expected %0d", stall_cnt, exp_cnt); failures++;
        end
        next_cycle();
    endtask

    task automatic test_dmiss();
        hazard_state_t exp_state;
        memREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_state = (i == 0) ? RUN : DWAIT;
            @(negedge CLK);
            assertions++;
            if (outs !== O_DMISS || dut.state_q !== exp_state) begin
                $display("FAIL dmiss_cycle%0d: outs=%b state=%0d expected %b state=%0d",
                         i, outs, dut.state_q, O_DMISS, exp_state);
                failures++;
            end
            next_cycle();
            exp_cnt = sat_inc(exp_cnt);
        end
        dhit = 1'b1;
        @(negedge CLK);
        assertions++;
        if (outs !== O_DEF || dut.state_q !== DWAIT) begin
            $display("FAIL dmiss_release: outs=%b state=%0d expected %b state=%0d",
                     outs, dut.state_q, O_DEF, DWAIT);
            failures++;
        end
        next_cycle();
        idle();
        @(negedge CLK);
        assertions++;
        if (dut.state_q !== RUN || stall_cnt !== exp_cnt) begin
            $display("FAIL dmiss_after: state=%0d cnt=%0d expected RUN cnt=%0d",
                     dut.state_q, stall_cnt, exp_cnt);
            failures++;
        end
        next_cycle();
    endtask

    task automatic test_dmiss_loaduse();
        memWEN = 1'b1; dhit = 1'b0; exMemToReg = 1'b1; exrt = 5'd12; idrs = 5'd12;
        @(negedge CLK);
        assertions++;
        if (outs !== O_DMISS) begin
            $display("FAIL dmiss_over_lu: got %b expected %b", outs, O_DMISS); failures++;
        end
        next_cycle();
        exp_cnt = sat_inc(exp_cnt);
        dhit = 1'b1;
        @(negedge CLK);
        assertions++;
        if (outs !== O_LU) begin
            $display("FAIL lu_after_dmiss: got %b expected %b", outs, O_LU); failures++;
        end
        next_cycle();
        exp_cnt = sat_inc(exp_cnt);
        idle();
        @(negedge CLK);
        assertions++;
        if (stall_cnt !== exp_cnt) begin
            $display("FAIL dmiss_lu_cnt: got %0d expected %0d", stall_cnt, exp_cnt); failures++;
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_dwait();
        memREN = 1'b1; dhit = 1'b0;
        next_cycle();
        RST = 1'b1;
        @(negedge CLK);
        assertions++;
        if (outs !== O_RST || dut.state_q !== DWAIT) begin
            $display("FAIL rst_in_dwait: outs=%b state=%0d expected %b state=%0d",
                     outs, dut.state_q, O_RST, DWAIT);
            failures++;
        end
        next_cycle();
        RST = 1'b0;
        idle();
        exp_cnt = '0;
        @(negedge CLK);
        assertions++;
        if (outs !== O_DEF || dut.state_q !== RUN || stall_cnt !== exp_cnt) begin
            $display("FAIL rst_from_dwait: outs=%b state=%0d cnt=%0d expected %b RUN 0",
                     outs, dut.state_q, stall_cnt, O_DEF);
            failures++;
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        ihit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            exp_cnt = sat_inc(exp_cnt);
        end
        @(negedge CLK);
        assertions++;
        if (stall_cnt !== exp_cnt || exp_cnt !== '1) begin
            $display("FAIL saturate: got %0d expected %0d", stall_cnt, exp_cnt); failures++;
        end
        next_cycle();
        idle();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_halt_then_reset();
        // Halt arrives together with a data miss: halt wins the transition.
        wbHALT = 1'b1; memREN = 1'b1; dhit = 1'b0;
        @(negedge CLK);
        assertions++;
        if (outs !== O_DMISS || halted !== 1'b0) begin
            $display("FAIL halt_entry: outs=%b halted=%b expected %b halted=0",
                     outs, halted, O_DMISS);
            failures++;
        end
        next_cycle();
        exp_cnt = sat_inc(exp_cnt);
        for (int i = 0; i < 10; i++) begin
            wbHALT = 1'b0;
            ihit = i[0]; dhit = i[1]; memREN = i[2]; memWEN = i[3];
            exBrTaken = i[1] ^ i[0]; idJump = i[2];
            exMemToReg = 1'b1; exrt = 5'd4; idrs = 5'd4;
            @(negedge CLK);
            assertions++;
            if (outs !== O_HALT || halted !== 1'b1 || stall_cnt !== exp_cnt ||
                dut.state_q !== HALTED) begin
                $display("FAIL halted_cycle%0d: outs=%b halted=%b cnt=%0d expected %b 1 %0d",
                         i, outs, halted, stall_cnt, O_HALT, exp_cnt);
                failures++;
            end
            next_cycle();
        end
        idle();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        assertions++;
        if (halted !== 1'b0 || stall_cnt !== '0 || dut.state_q !== RUN || outs !== O_DEF) begin
            $display("FAIL halt_reset: halted=%b cnt=%0d state=%0d outs=%b expected 0 0 RUN %b",
                     halted, stall_cnt, dut.state_q, outs, O_DEF);
            failures++;
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_r0();
        test_branch();
        test_jump_imiss();
        test_dmiss();
        test_dmiss_loaduse();
        test_reset_mid_dwait();
        test_saturation();
        test_halt_then_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
